// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;

  modport master (output start, x, y, bin, input busy, done, d, bout, zero);
  modport slave  (input start, x, y, bin, output busy, done, d, bout, zero);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: d = x - y - bin, one bit per cycle
// through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_subtractor_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             last;

  logic             busy_q, done_q, bout_q, zero_q;
  logic [WIDTH-1:0] d_q;

  // Full-subtractor cell on the current LSBs
  logic             a, b, s, br_nx;
  logic [WIDTH-1:0] r_nx;

  assign a     = a_sr[0];
  assign b     = b_sr[0];
  assign s     = a ^ b ^ br;
  assign br_nx = (~a & b) | (~(a ^ b) & br);
  assign r_nx  = {s, r_sr[WIDTH-1:1]};
  assign last  = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch, serial shift, result capture; busy/done are
  // registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      busy_q <= (state_nx != IDLE);
      done_q <= (state_nx == DONE);
      case (state)
        IDLE: if (bus.start) begin
          a_sr <= bus.x;
          b_sr <= bus.y;
          br   <= bus.bin;
          r_sr <= '0;
          cnt  <= '0;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nx;
          br   <= br_nx;
          cnt  <= cnt + 1'b1;
          // Final bit: publish result including the bit computed this cycle
          if (last) begin
            d_q    <= r_nx;
            bout_q <= br_nx;
            zero_q <= (r_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4) against an
// arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  // Model of the registered result (what d/bout/zero should hold)
  logic [W-1:0] m_d;
  logic         m_bout;
  logic         m_zero;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer subtraction
  task automatic model(input int xv, input int yv, input int bv,
                       output logic [W-1:0] ed, output logic eb, output logic ez);
    int diff;
    diff = xv - yv - bv;
    ed = W'(diff);
    eb = (diff < 0);
    ez = (W'(diff) == '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.bin = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_d = '0; m_bout = 1'b0; m_zero = 1'b1;
    n_chk++;
    if ({bus.busy, bus.done, bus.d, bus.bout, bus.zero} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1})
      $display("FAIL reset: busy=%b done=%b d=%0d bout=%b zero=%b, want 0 0 0 0 1",
               bus.busy, bus.done, bus.d, bus.bout, bus.zero);
    else n_pass++;
  endtask

  // One full operation with cycle-by-cycle handshake and hold checks
  task automatic run_op(input int xv, input int yv, input int bv, input string tag);
    logic [W-1:0] ed;
    logic eb, ez;
    model(xv, yv, bv, ed, eb, ez);
    bus.x = W'(xv); bus.y = W'(yv); bus.bin = bv[0]; bus.start = 1'b1;
    tick();                       // now cycle 1
    bus.start = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      n_chk++;
      if (bus.busy !== 1'b1 || bus.done !== (c == W + 1))
        $display("FAIL %s handshake c%0d: busy=%b done=%b, want 1 %b",
                 tag, c, bus.busy, bus.done, (c == W + 1));
      else n_pass++;
      if (c == W + 1) begin
        m_d = ed; m_bout = eb; m_zero = ez;
      end
      n_chk++;
      if (bus.d !== m_d || bus.bout !== m_bout || bus.zero !== m_zero)
        $display("FAIL %s result c%0d: d=%0d bout=%b zero=%b, want %0d %b %b",
                 tag, c, bus.d, bus.bout, bus.zero, m_d, m_bout, m_zero);
      else n_pass++;
      // Scramble inputs; they must be ignored after acceptance
      bus.x = W'($urandom); bus.y = W'($urandom); bus.bin = 1'($urandom);
      bus.start = (c < W + 1) ? 1'($urandom) : 1'b0;
      tick();
    end
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL %s idle: busy=%b done=%b, want 0 0", tag, bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_op(15, 6, 0, "no_borrow");
    run_op(4, 9, 0, "negative");
    run_op(0, 0, 1, "neg_bin");
    run_op(10, 10, 0, "zero");
  endtask

  task automatic test_back_to_back();
    int q_x[$], q_y[$], q_b[$];
    int last_acc, n_acc;
    logic pb, idle_miss;
    logic [W-1:0] ed;
    logic eb, ez;
    int xv, yv, bv;
    last_acc = -1; n_acc = 0; idle_miss = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      pb = bus.busy;
      xv = int'($urandom_range(15)); yv = int'($urandom_range(15)); bv = int'($urandom_range(1));
      bus.x = W'(xv); bus.y = W'(yv); bus.bin = bv[0];
      tick();
      if (!pb && bus.busy) begin
        q_x.push_back(xv); q_y.push_back(yv); q_b.push_back(bv);
        if (last_acc >= 0) begin
          n_chk++;
          if (cyc - last_acc != W + 2)
            $display("FAIL b2b interval: got %0d cycles, want %0d", cyc - last_acc, W + 2);
          else n_pass++;
        end
        last_acc = cyc;
        n_acc++;
      end else if (!pb) idle_miss = 1'b1;
      if (bus.done) begin
        n_chk++;
        if (q_x.size() == 0) $display("FAIL b2b done without accept: got done=1, want 0");
        else begin
          model(q_x.pop_front(), q_y.pop_front(), q_b.pop_front(), ed, eb, ez);
          m_d = ed; m_bout = eb; m_zero = ez;
          if (bus.d !== ed || bus.bout !== eb || bus.zero !== ez)
            $display("FAIL b2b result: d=%0d bout=%b zero=%b, want %0d %b %b",
                     bus.d, bus.bout, bus.zero, ed, eb, ez);
          else n_pass++;
        end
      end
    end
    bus.start = 1'b0;
    for (int k = 0; k < 10 && q_x.size() != 0; k++) begin
      tick();
      if (bus.done) begin
        model(q_x.pop_front(), q_y.pop_front(), q_b.pop_front(), ed, eb, ez);
        m_d = ed; m_bout = eb; m_zero = ez;
        n_chk++;
        if (bus.d !== ed || bus.bout !== eb || bus.zero !== ez)
          $display("FAIL b2b drain: d=%0d bout=%b zero=%b, want %0d %b %b",
                   bus.d, bus.bout, bus.zero, ed, eb, ez);
        else n_pass++;
      end
    end
    tick(); tick();
    n_chk++;
    if (n_acc != 7 || q_x.size() != 0 || idle_miss)
      $display("FAIL b2b accepts: got %0d (pending %0d, idle_miss %b), want 7 (0, 0)",
               n_acc, q_x.size(), idle_miss);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    bus.x = 4'd15; bus.y = 4'd1; bus.bin = 1'b0; bus.start = 1'b1;
    tick();                       // cycle 1
    bus.start = 1'b0;
    tick();                       // cycle 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_d = '0; m_bout = 1'b0; m_zero = 1'b1;
    n_chk++;
    if ({bus.busy, bus.done, bus.d, bus.bout, bus.zero} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1})
      $display("FAIL mid_reset: busy=%b done=%b d=%0d bout=%b zero=%b, want 0 0 0 0 1",
               bus.busy, bus.done, bus.d, bus.bout, bus.zero);
    else n_pass++;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done) $display("FAIL mid_reset aborted: got activity=1, want 0");
    else n_pass++;
    // Reset and start together: reset wins
    reset = 1'b1; bus.start = 1'b1;
    tick();
    reset = 1'b0; bus.start = 1'b0;
    tick();
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL reset_vs_start: busy=%b, want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_sweep();
    for (int xv = 0; xv < 16; xv++)
      for (int yv = 0; yv < 16; yv++)
        for (int bv = 0; bv < 2; bv++)
          run_op(xv, yv, bv, "sweep");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
